// File: rtl/feat_bram_writer.sv
// Feature BRAM writer: accepts one node's feature vector per handshake and
// streams its elements, one per cycle, into the new-feature BRAM through port A.
// Every output comes straight from a register.
module feat_bram_writer #(
    parameter int unsigned DATA_WIDTH         = 8,
    parameter int unsigned NUM_FEATURE_OUT    = 16,
    parameter int unsigned NUM_SUBGRAPHS      = 2708,
    parameter int unsigned NEW_FEATURE_DEPTH  = NUM_SUBGRAPHS * NUM_FEATURE_OUT,
    parameter int unsigned NEW_FEATURE_ADDR_W = $clog2(NEW_FEATURE_DEPTH)
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    start,
    input  logic                                    feat_vld,
    input  logic [DATA_WIDTH*NUM_FEATURE_OUT-1:0]   feat_data,
    output logic                                    feat_rdy,
    output logic [DATA_WIDTH-1:0]                   feat_bram_din,
    output logic                                    feat_bram_ena,
    output logic                                    feat_bram_wea,
    output logic [NEW_FEATURE_ADDR_W-1:0]           feat_bram_addra,
    output logic                                    gat_ready,
    output logic [$clog2(NUM_SUBGRAPHS+1)-1:0]      node_cnt
);

    localparam int unsigned VecW  = DATA_WIDTH * NUM_FEATURE_OUT;
    localparam int unsigned CntW  = $clog2(NUM_SUBGRAPHS + 1);
    localparam int unsigned ElemW = (NUM_FEATURE_OUT > 1) ? $clog2(NUM_FEATURE_OUT) : 1;
    localparam int unsigned AddrW = NEW_FEATURE_ADDR_W;

    localparam logic [ElemW-1:0] LastElem = ElemW'(NUM_FEATURE_OUT - 1);
    localparam logic [CntW-1:0]  LastNode = CntW'(NUM_SUBGRAPHS - 1);

    typedef enum logic [1:0] {StIdle, StWait, StWrite, StDone} state_e;

    state_e            state_q, state_d;
    logic [VecW-1:0]   hold_q, hold_d;          // remaining elements, next one in the low bits
    logic [ElemW-1:0]  elem_q, elem_d;          // index of the element currently on din
    logic [AddrW-1:0]  next_addr_q, next_addr_d;
    logic              rdy_q, rdy_d;
    logic              ena_q, ena_d;
    logic [DATA_WIDTH-1:0] din_q, din_d;
    logic [AddrW-1:0]  addr_q, addr_d;
    logic              gat_q, gat_d;
    logic [CntW-1:0]   cnt_q, cnt_d;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; start is only honoured between runs
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle, StDone: begin
                if (start) state_d = StWait;
            end
            StWait: begin
                if (feat_vld) state_d = StWrite;
            end
            StWrite: begin
                if (elem_q == LastElem) begin
                    state_d = (cnt_q == LastNode) ? StDone : StWait;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output/datapath next values; the transfer edge already loads element 0
    always_comb begin
        hold_d      = hold_q;
        elem_d      = elem_q;
        next_addr_d = next_addr_q;
        ena_d       = 1'b0;
        din_d       = din_q;
        addr_d      = addr_q;
        gat_d       = gat_q;
        cnt_d       = cnt_q;
        rdy_d       = (state_d == StWait);
        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    next_addr_d = '0;
                    addr_d      = '0;
                    cnt_d       = '0;
                    gat_d       = 1'b0;
                end
            end
            StWait: begin
                if (feat_vld) begin
                    hold_d      = feat_data >> DATA_WIDTH;
                    din_d       = feat_data[DATA_WIDTH-1:0];
                    addr_d      = next_addr_q;
                    next_addr_d = next_addr_q + AddrW'(1);
                    elem_d      = '0;
                    ena_d       = 1'b1;
                end
            end
            StWrite: begin
                if (elem_q == LastElem) begin
                    // Last element of this node has just been written
                    cnt_d = cnt_q + CntW'(1);
                    gat_d = (cnt_q == LastNode);
                end else begin
                    hold_d      = hold_q >> DATA_WIDTH;
                    din_d       = hold_q[DATA_WIDTH-1:0];
                    addr_d      = next_addr_q;
                    next_addr_d = next_addr_q + AddrW'(1);
                    elem_d      = elem_q + ElemW'(1);
                    ena_d       = 1'b1;
                end
            end
            default: begin
                ena_d = 1'b0;
            end
        endcase
    end

    // Datapath and output registers; reset aborts any write in progress
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q      <= '0;
            elem_q      <= '0;
            next_addr_q <= '0;
            rdy_q       <= 1'b0;
            ena_q       <= 1'b0;
            din_q       <= '0;
            addr_q      <= '0;
            gat_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            hold_q      <= hold_d;
            elem_q      <= elem_d;
            next_addr_q <= next_addr_d;
            rdy_q       <= rdy_d;
            ena_q       <= ena_d;
            din_q       <= din_d;
            addr_q      <= addr_d;
            gat_q       <= gat_d;
            cnt_q       <= cnt_d;
        end
    end

    assign feat_rdy        = rdy_q;
    assign feat_bram_ena   = ena_q;
    assign feat_bram_wea   = ena_q;
    assign feat_bram_din   = din_q;
    assign feat_bram_addra = addr_q;
    assign gat_ready       = gat_q;
    assign node_cnt        = cnt_q;

endmodule

// File: tb/tb_feat_bram_writer.sv
// Bench for feat_bram_writer with a small 4-element, 3-node configuration.
module tb_feat_bram_writer;

    localparam int DW  = 8;
    localparam int NFO = 4;
    localparam int NS  = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        feat_vld = 1'b0;
    logic [31:0] feat_data = '0;
    logic        feat_rdy;
    logic [7:0]  feat_bram_din;
    logic        feat_bram_ena;
    logic        feat_bram_wea;
    logic [3:0]  feat_bram_addra;
    logic        gat_ready;
    logic [1:0]  node_cnt;

    feat_bram_writer #(
        .DATA_WIDTH      (DW),
        .NUM_FEATURE_OUT (NFO),
        .NUM_SUBGRAPHS   (NS)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .feat_vld        (feat_vld),
        .feat_data       (feat_data),
        .feat_rdy        (feat_rdy),
        .feat_bram_din   (feat_bram_din),
        .feat_bram_ena   (feat_bram_ena),
        .feat_bram_wea   (feat_bram_wea),
        .feat_bram_addra (feat_bram_addra),
        .gat_ready       (gat_ready),
        .node_cnt        (node_cnt)
    );

    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;

    typedef struct {
        logic        s;
        logic        v;
        logic [31:0] d;
        logic        rdy;
        logic        ena;
        logic [7:0]  din;
        logic [3:0]  addr;
        logic        gat;
        logic [1:0]  cnt;
    } vec_t;

    vec_t tbl[19];

    task automatic check(input string name, input logic rdy, input logic ena,
                         input logic [7:0] din, input logic [3:0] addr,
                         input logic gat, input logic [1:0] cnt);
        total_cnt++;
        if (feat_rdy === rdy && feat_bram_ena === ena && feat_bram_wea === ena &&
            feat_bram_din === din && feat_bram_addra === addr &&
            gat_ready === gat && node_cnt === cnt) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got rdy=%b ena=%b wea=%b din=%h addr=%0d gat=%b cnt=%0d; want rdy=%b ena=%b wea=%b din=%h addr=%0d gat=%b cnt=%0d",
                     name, feat_rdy, feat_bram_ena, feat_bram_wea, feat_bram_din,
                     feat_bram_addra, gat_ready, node_cnt,
                     rdy, ena, ena, din, addr, gat, cnt);
        end
    endtask

    // Drive inputs on the falling edge, then sample just after the rising edge
    task automatic step(input logic s, input logic v, input logic [31:0] d);
        @(negedge clk);
        start     = s;
        feat_vld  = v;
        feat_data = d;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        start    = 1'b0;
        feat_vld = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Reference model: transaction-level view of a run
    int          m_phase;       // 0 idle, 1 run active, 2 run done
    int          m_nodes;
    int          m_base;
    bit          m_last_pending;
    logic [7:0]  q_din[$];
    int          q_addr[$];
    logic        e_rdy, e_ena, e_gat;
    logic [7:0]  e_din;
    int          e_addr, e_cnt;

    task automatic model_init();
        m_phase = 0; m_nodes = 0; m_base = 0; m_last_pending = 0;
        q_din.delete(); q_addr.delete();
        e_rdy = 0; e_ena = 0; e_gat = 0; e_din = '0; e_addr = 0; e_cnt = 0;
    endtask

    task automatic model_edge(input logic s, input logic v, input logic [31:0] d);
        int  ph0;
        bit  xfer;
        ph0  = m_phase;
        xfer = e_rdy && v;
        if (m_last_pending) begin
            m_last_pending = 0;
            m_nodes++;
            e_cnt = m_nodes;
            if (m_nodes == NS) begin
                m_phase = 2;
                e_gat   = 1;
            end
        end
        if (s && ph0 != 1) begin
            m_phase = 1; m_nodes = 0; m_base = 0;
            e_cnt = 0; e_gat = 0; e_addr = 0;
        end else if (xfer) begin
            for (int k = 0; k < NFO; k++) begin
                q_din.push_back(d[k*DW +: DW]);
                q_addr.push_back(m_base + k);
            end
            m_base += NFO;
        end
        e_ena = 0;
        if (q_din.size() > 0) begin
            e_ena  = 1;
            e_din  = q_din.pop_front();
            e_addr = q_addr.pop_front();
            if (q_din.size() == 0) m_last_pending = 1;
        end
        e_rdy = (m_phase == 1) && !e_ena;
    endtask

    initial begin
        int         nwr;
        int         bad;
        logic [3:0] wa[$];
        logic [7:0] wd[$];
        int         stray;
        logic       s, v;
        logic [31:0] d;

        tbl[0]  = '{1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 8'h00, 4'd0,  1'b0, 2'd0};
        tbl[1]  = '{1'b0, 1'b1, 32'h44332211, 1'b0, 1'b1, 8'h11, 4'd0,  1'b0, 2'd0};
        tbl[2]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 8'h22, 4'd1,  1'b0, 2'd0};
        tbl[3]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 8'h33, 4'd2,  1'b0, 2'd0};
        tbl[4]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 8'h44, 4'd3,  1'b0, 2'd0};
        tbl[5]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 8'h44, 4'd3,  1'b0, 2'd1};
        tbl[6]  = '{1'b1, 1'b1, 32'hDDCCBBAA, 1'b0, 1'b1, 8'hAA, 4'd4,  1'b0, 2'd1};
        tbl[7]  = '{1'b0, 1'b0, 32'hDEADBEEF, 1'b0, 1'b1, 8'hBB, 4'd5,  1'b0, 2'd1};
        tbl[8]  = '{1'b1, 1'b1, 32'h12345678, 1'b0, 1'b1, 8'hCC, 4'd6,  1'b0, 2'd1};
        tbl[9]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 8'hDD, 4'd7,  1'b0, 2'd1};
        tbl[10] = '{1'b0, 1'b1, 32'h87654321, 1'b1, 1'b0, 8'hDD, 4'd7,  1'b0, 2'd2};
        tbl[11] = '{1'b0, 1'b1, 32'h87654321, 1'b0, 1'b1, 8'h21, 4'd8,  1'b0, 2'd2};
        tbl[12] = '{1'b0, 1'b1, 32'h87654321, 1'b0, 1'b1, 8'h43, 4'd9,  1'b0, 2'd2};
        tbl[13] = '{1'b0, 1'b1, 32'h87654321, 1'b0, 1'b1, 8'h65, 4'd10, 1'b0, 2'd2};
        tbl[14] = '{1'b0, 1'b1, 32'h87654321, 1'b0, 1'b1, 8'h87, 4'd11, 1'b0, 2'd2};
        tbl[15] = '{1'b0, 1'b1, 32'h87654321, 1'b0, 1'b0, 8'h87, 4'd11, 1'b1, 2'd3};
        tbl[16] = '{1'b0, 1'b1, 32'h87654321, 1'b0, 1'b0, 8'h87, 4'd11, 1'b1, 2'd3};
        tbl[17] = '{1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 8'h87, 4'd0,  1'b0, 2'd0};
        tbl[18] = '{1'b0, 1'b1, 32'h04030201, 1'b0, 1'b1, 8'h01, 4'd0,  1'b0, 2'd0};

        // Reset state
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset", 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 2'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven run: basic node, ignored start/vld, full run, restart from DONE
        foreach (tbl[i]) begin
            step(tbl[i].s, tbl[i].v, tbl[i].d);
            check($sformatf("vec%0d", i), tbl[i].rdy, tbl[i].ena, tbl[i].din,
                  tbl[i].addr, tbl[i].gat, tbl[i].cnt);
        end

        // Three vectors back to back with feat_vld held high
        do_reset();
        step(1'b1, 1'b0, 32'h0);
        wa.delete(); wd.delete();
        for (int c = 0; c < 20; c++) begin
            step(1'b0, 1'b1, 32'h44332211);
            if (feat_bram_ena === 1'b1) begin
                wa.push_back(feat_bram_addra);
                wd.push_back(feat_bram_din);
            end
        end
        nwr = wa.size();
        total_cnt++;
        if (nwr == 12) pass_cnt++;
        else $display("FAIL b2b_count: got %0d writes, want 12", nwr);
        bad = 0;
        foreach (wa[i]) begin
            if (wa[i] !== 4'(i) || wd[i] !== 8'(8'h11 * ((i % NFO) + 1))) bad++;
        end
        total_cnt++;
        if (bad == 0) pass_cnt++;
        else $display("FAIL b2b_data: got %0d bad writes, want 0", bad);
        check("b2b_done", 1'b0, 1'b0, 8'h44, 4'd11, 1'b1, 2'd3);

        // Asynchronous reset during the 2nd element of node 1
        do_reset();
        step(1'b1, 1'b0, 32'h0);
        for (int c = 0; c < 7; c++) step(1'b0, 1'b1, 32'hA4A3A2A1);
        check("pre_reset_node1", 1'b0, 1'b1, 8'hA2, 4'd5, 1'b0, 2'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_async", 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 2'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        stray = 0;
        for (int c = 0; c < 8; c++) begin
            step(1'b0, 1'b1, 32'hA4A3A2A1);
            if (feat_bram_ena !== 1'b0 || feat_rdy !== 1'b0) stray++;
        end
        total_cnt++;
        if (stray == 0) pass_cnt++;
        else $display("FAIL no_write_after_reset: got %0d active cycles, want 0", stray);
        step(1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b1, 32'h55667788);
        check("post_reset_first", 1'b0, 1'b1, 8'h88, 4'd0, 1'b0, 2'd0);

        // Randomized stimulus against the reference model
        do_reset();
        model_init();
        for (int c = 0; c < 600; c++) begin
            s = ($urandom_range(0, 9) == 0);
            v = $urandom_range(0, 1) == 1;
            d = $urandom;
            step(s, v, d);
            model_edge(s, v, d);
            check($sformatf("rand%0d", c), e_rdy, e_ena, e_din, 4'(e_addr), e_gat, 2'(e_cnt));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
